pixel_stream_sequencer: RTL and testbench



---
 rtl/pixel_stream_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_pixel_stream_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_sequencer.sv
// pixel_stream_sequencer: issues scan coordinates into a fixed-latency pipeline and re-tags returned colours.
// Latency: start -> first coord 1 cycle; res_valid -> px_valid 1 cycle through the FWFT result buffer.
// Backpressure: px_ready stalls the buffer; credits (outstanding + buffered <= MAX_INFLIGHT) stop issue, nothing drops.
//
// Ports:
//   clk, rst                 sole clock, synchronous active-high reset
//   start, continuous        arm a frame / keep issuing frames back to back
//   coord_x/_y, coord_valid  coordinate to the ray pipeline (no ready)
//   res_valid, res_color     in-order {r,g,b} results from the pipeline
//   px_r/g/b, px_sof/eol     head pixel to the packer, valid/ready handshake
//   frame_done, busy, inflight, seq_err  status

// sync_fifo: generic first-word-fall-through FIFO, pointer-based storage.
// Latency: a push is visible at pop_dat the cycle after it is written.
// Backpressure: none internally; callers guarantee no push when full and no pop when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CNTW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic [CNTW-1:0]  count,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNTW-1:0]  cnt;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign pop_dat = mem[rd_ptr];
    assign count   = cnt;
    assign empty   = (cnt == '0);
endmodule

module pixel_stream_sequencer #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int COLOR_WIDTH  = 8,
    parameter int MAX_INFLIGHT = 64,
    localparam int XW = $clog2(H_RES),
    localparam int YW = $clog2(V_RES),
    localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     continuous,
    output logic [XW-1:0]            coord_x,
    output logic [YW-1:0]            coord_y,
    output logic                     coord_valid,
    input  logic                     res_valid,
    input  logic [3*COLOR_WIDTH-1:0] res_color,
    output logic [COLOR_WIDTH-1:0]   px_r,
    output logic [COLOR_WIDTH-1:0]   px_g,
    output logic [COLOR_WIDTH-1:0]   px_b,
    output logic                     px_sof,
    output logic                     px_eol,
    output logic                     px_valid,
    input  logic                     px_ready,
    output logic                     frame_done,
    output logic                     busy,
    output logic [CW-1:0]            inflight,
    output logic                     seq_err
);
    localparam int TAG_W = 3;                       // {last, sof, eol}
    localparam int OUT_W = TAG_W + 3 * COLOR_WIDTH;
    localparam int CW1   = CW + 1;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t state;
    state_t state_nxt;

    logic [XW-1:0]    x_cnt;
    logic [YW-1:0]    y_cnt;
    logic             last_x;
    logic             last_y;
    logic             run;
    logic             issue;
    logic             accept;
    logic             px_pop;
    logic [CW:0]      credit_sum;
    logic [TAG_W-1:0] tag_head;
    logic             tag_empty;
    logic [CW-1:0]    tag_count;    // doubles as the outstanding-pixel count
    logic [OUT_W-1:0] out_head;
    logic             out_empty;
    logic [CW-1:0]    buf_count;

    assign run        = (state == ST_RUN);
    assign last_x     = (x_cnt == XW'(H_RES - 1));
    assign last_y     = (y_cnt == YW'(V_RES - 1));
    assign credit_sum = {1'b0, tag_count} + {1'b0, buf_count};
    assign issue      = run && (credit_sum < CW1'(MAX_INFLIGHT));
    // Every outstanding pixel owns a tag, so an empty tag FIFO means a stray result.
    assign accept     = res_valid && !tag_empty;
    assign px_valid   = !out_empty;
    assign px_pop     = px_valid && px_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stopping only at the last pixel keeps the scan counters at (0,0) whenever idle,
    // so a start always begins on a frame boundary.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (issue && last_x && last_y && !continuous) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (issue) begin
            if (last_x) begin
                x_cnt <= '0;
                y_cnt <= last_y ? '0 : y_cnt + 1'b1;
            end else begin
                x_cnt <= x_cnt + 1'b1;
            end
        end
    end

    sync_fifo #(.WIDTH(TAG_W), .DEPTH(MAX_INFLIGHT)) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (issue),
        .push_dat ({last_x && last_y, (x_cnt == '0) && (y_cnt == '0), last_x}),
        .pop      (accept),
        .pop_dat  (tag_head),
        .count    (tag_count),
        .empty    (tag_empty)
    );

    sync_fifo #(.WIDTH(OUT_W), .DEPTH(MAX_INFLIGHT)) u_out_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (accept),
        .push_dat ({tag_head, res_color}),
        .pop      (px_pop),
        .pop_dat  (out_head),
        .count    (buf_count),
        .empty    (out_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_done <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            frame_done <= px_pop && out_head[OUT_W-1];
            if (res_valid && tag_empty) begin
                seq_err <= 1'b1;
            end
        end
    end

    // Masking with px_valid keeps the packer-facing bus at zero while the buffer is empty.
    assign px_sof = px_valid && out_head[OUT_W-2];
    assign px_eol = px_valid && out_head[OUT_W-3];
    assign px_r   = px_valid ? out_head[3*COLOR_WIDTH-1 -: COLOR_WIDTH] : '0;
    assign px_g   = px_valid ? out_head[2*COLOR_WIDTH-1 -: COLOR_WIDTH] : '0;
    assign px_b   = px_valid ? out_head[COLOR_WIDTH-1 -: COLOR_WIDTH]   : '0;

    assign coord_x     = x_cnt;
    assign coord_y     = y_cnt;
    assign coord_valid = issue;
    assign busy        = run || (tag_count != '0) || (buf_count != '0);
    assign inflight    = tag_count + buf_count;
endmodule

// File: tb/tb_pixel_stream_sequencer.sv
// tb_pixel_stream_sequencer: scoreboard bench for a 4x2 frame with four credits.
// Latency: the pipeline model returns a result in the D-th cycle counting the issue cycle.
// Backpressure: px_ready driven directly or randomly by the stimulus process.
module tb_pixel_stream_sequencer;
    localparam int H = 4;
    localparam int V = 2;
    localparam int MAXF = 4;

    logic        clk = 1'b0;
    logic        rst, start, continuous, res_valid, px_ready;
    logic [23:0] res_color;
    logic [1:0]  coord_x;
    logic        coord_y;
    logic        coord_valid;
    logic [7:0]  px_r, px_g, px_b;
    logic        px_sof, px_eol, px_valid, frame_done, busy, seq_err;
    logic [2:0]  inflight;

    pixel_stream_sequencer #(.H_RES(H), .V_RES(V), .COLOR_WIDTH(8), .MAX_INFLIGHT(MAXF)) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous),
        .coord_x(coord_x), .coord_y(coord_y), .coord_valid(coord_valid),
        .res_valid(res_valid), .res_color(res_color),
        .px_r(px_r), .px_g(px_g), .px_b(px_b), .px_sof(px_sof), .px_eol(px_eol),
        .px_valid(px_valid), .px_ready(px_ready), .frame_done(frame_done),
        .busy(busy), .inflight(inflight), .seq_err(seq_err)
    );

    initial forever #5 clk = ~clk;

    typedef struct { logic sof; logic eol; logic last; logic [23:0] col; } exp_t;
    typedef struct { int due; logic [23:0] col; } pipe_t;

    exp_t  sb[$];
    pipe_t pq[$];
    int    total = 0, bad = 0;
    int    cyc = 0, delay = 3;
    int    issue_cnt = 0, issue_seq = 0, fd_cnt = 0, gaps = 0;
    int    first_issue_cyc = 0, last_issue_cyc = 0;
    int    exp_x = 0, exp_y = 0;
    int    s_cyc, n;
    logic  inject = 1'b0, chk_inflight = 1'b0, prev_stall = 1'b0, exp_fd = 1'b0;
    logic [26:0] prev_snap;
    exp_t  e, e_new;
    pipe_t p_new;
    logic [23:0] col;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_coord_valid"}, coord_valid, 0);
        check({tag, "_coord_x"}, coord_x, 0);
        check({tag, "_coord_y"}, coord_y, 0);
        check({tag, "_px_valid"}, px_valid, 0);
        check({tag, "_px_sof"}, px_sof, 0);
        check({tag, "_px_eol"}, px_eol, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_inflight"}, inflight, 0);
        check({tag, "_seq_err"}, seq_err, 0);
    endtask

    task automatic clear_counts();
        issue_cnt = 0;
        fd_cnt    = 0;
        gaps      = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        s_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_idle(input string name, input int limit, input bit rnd);
        int k = 0;
        while ((busy || sb.size() != 0) && k < limit) begin
            if (rnd) px_ready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        px_ready = 1'b1;
        check({name, "_idle_busy"}, busy, 0);
        check({name, "_idle_pending"}, sb.size(), 0);
        tick();
        tick();
    endtask

    // Pipeline model: fixed latency, plus a one-shot stray result for the sequence-error case.
    initial begin
        res_valid = 1'b0;
        res_color = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            res_valid = 1'b0;
            res_color = '0;
            if (inject) begin
                res_valid = 1'b1;
                res_color = 24'hABCDEF;
                inject    = 1'b0;
            end else if (pq.size() != 0 && pq[0].due == cyc) begin
                res_valid = 1'b1;
                res_color = pq[0].col;
                void'(pq.pop_front());
            end
        end
    end

    // Monitor: records issues against the scan model, checks pixels against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (coord_valid) begin
            check("coord_x", coord_x, exp_x);
            check("coord_y", coord_y, exp_y);
            if (issue_cnt == 0) first_issue_cyc = cyc;
            else if (cyc != last_issue_cyc + 1) gaps++;
            last_issue_cyc = cyc;
            col = {8'(issue_seq), 4'(exp_x), 4'(exp_y), ~8'(issue_seq)};
            e_new.sof  = (exp_x == 0 && exp_y == 0);
            e_new.eol  = (exp_x == H - 1);
            e_new.last = (exp_x == H - 1 && exp_y == V - 1);
            e_new.col  = col;
            sb.push_back(e_new);
            p_new.due = cyc + delay - 1;
            p_new.col = col;
            pq.push_back(p_new);
            issue_cnt++;
            issue_seq++;
            if (exp_x == H - 1) begin
                exp_x = 0;
                exp_y = (exp_y == V - 1) ? 0 : exp_y + 1;
            end else begin
                exp_x++;
            end
        end
        if (rst) begin
            prev_stall = 1'b0;
            exp_fd     = 1'b0;
        end else begin
            check("frame_done", frame_done, exp_fd);
            if (frame_done) fd_cnt++;
            exp_fd = 1'b0;
            if (prev_stall) check("stall_hold", {px_valid, px_sof, px_eol, px_r, px_g, px_b}, prev_snap);
            if (chk_inflight) check("inflight_over_max", inflight > 3'(MAXF), 0);
            if (px_valid && px_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL px_unexpected: got pixel %h, nothing expected", {px_r, px_g, px_b});
                end else begin
                    e = sb.pop_front();
                    check("px_color", {px_r, px_g, px_b}, e.col);
                    check("px_sof", px_sof, e.sof);
                    check("px_eol", px_eol, e.eol);
                    exp_fd = e.last;
                end
            end
            prev_stall = px_valid && !px_ready;
            prev_snap  = {px_valid, px_sof, px_eol, px_r, px_g, px_b};
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; continuous = 1'b0; px_ready = 1'b1;
        tick();
        tick();
        check_reset_vals("reset");
        rst = 1'b0;
        tick();

        // Single frame, no back-pressure: eight back-to-back coordinates.
        delay = 3;
        clear_counts();
        pulse_start();
        run_until_idle("t1", 100, 0);
        check("t1_start_latency", first_issue_cyc, s_cyc + 1);
        check("t1_issue_cnt", issue_cnt, 8);
        check("t1_gaps", gaps, 0);
        check("t1_frame_done_cnt", fd_cnt, 1);
        check("t1_inflight", inflight, 0);

        // Packer stalled: credits run out at four.
        clear_counts();
        px_ready = 1'b0;
        pulse_start();
        repeat (20) tick();
        check("t2_issue_cnt_stalled", issue_cnt, 4);
        check("t2_inflight_full", inflight, 4);
        check("t2_coord_valid_stalled", coord_valid, 0);
        check("t2_px_valid_stalled", px_valid, 1);
        px_ready = 1'b1;
        run_until_idle("t2", 100, 0);
        check("t2_issue_cnt", issue_cnt, 8);
        check("t2_frame_done_cnt", fd_cnt, 1);

        // Continuous: three frames with no gap at the wrap, then stop.
        clear_counts();
        continuous = 1'b1;
        pulse_start();
        n = 0;
        while (issue_cnt < 17 && n < 100) begin
            tick();
            n++;
        end
        continuous = 1'b0;
        run_until_idle("t3", 100, 0);
        check("t3_issue_cnt", issue_cnt, 24);
        check("t3_gaps", gaps, 0);
        check("t3_frame_done_cnt", fd_cnt, 3);
        repeat (5) tick();
        check("t3_no_extra_issue", issue_cnt, 24);

        // Random back-pressure, long pipeline, two frames.
        delay = 7;
        chk_inflight = 1'b1;
        clear_counts();
        continuous = 1'b1;
        pulse_start();
        n = 0;
        while (issue_cnt < 9 && n < 200) begin
            px_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        continuous = 1'b0;
        run_until_idle("t4", 400, 1);
        chk_inflight = 1'b0;
        check("t4_issue_cnt", issue_cnt, 16);
        check("t4_frame_done_cnt", fd_cnt, 2);

        // Stray result with nothing outstanding.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_seq_err_clear", seq_err, 0);
        inject = 1'b1;
        tick();
        tick();
        check("t5_seq_err_set", seq_err, 1);
        check("t5_px_valid", px_valid, 0);
        check("t5_inflight", inflight, 0);
        repeat (5) tick();
        check("t5_seq_err_sticky", seq_err, 1);

        // Reset mid-frame, stale results afterwards, then a clean restart.
        clear_counts();
        pulse_start();
        n = 0;
        while (issue_cnt < 3 && n < 50) begin
            tick();
            n++;
        end
        check("t6_busy_before_rst", busy, 1);
        rst = 1'b1;
        tick();
        check_reset_vals("t6_rst");
        sb.delete();
        exp_x = 0;
        exp_y = 0;
        rst = 1'b0;
        n = 0;
        while (pq.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        tick();
        check("t6_stale_seq_err", seq_err, 1);
        check("t6_stale_px_valid", px_valid, 0);
        check("t6_stale_busy", busy, 0);
        clear_counts();
        pulse_start();
        run_until_idle("t6", 200, 0);
        check("t6_start_latency", first_issue_cyc, s_cyc + 1);
        check("t6_issue_cnt", issue_cnt, 8);
        check("t6_frame_done_cnt", fd_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
